// File: rtl/wbs_accumulator_if.sv
`default_nettype none
// ============================================================================
// Module      : wbs_accumulator_if
// Description : Bundles the controller-facing operand inputs and the result
//               port of wbs_accumulator. The master side drives operands and
//               ready; the slave side is the accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
interface wbs_accumulator_if #(
    parameter int DW = 6,
    parameter int AW = 13
);
    logic [DW-1:0] w_in;
    logic          load_w_in;
    logic          cnt_in;
    logic [DW-1:0] b_in;
    logic [DW-1:0] s_in;
    logic          ready_in;
    logic [AW-1:0] result_out;
    logic [DW-1:0] count_out;
    logic          valid_out;
    logic          busy_out;
    logic          lost_out;

    modport master (
        output w_in, load_w_in, cnt_in, b_in, s_in, ready_in,
        input  result_out, count_out, valid_out, busy_out, lost_out
    );

    modport slave (
        input  w_in, load_w_in, cnt_in, b_in, s_in, ready_in,
        output result_out, count_out, valid_out, busy_out, lost_out
    );
endinterface
`default_nettype wire

// File: rtl/wbs_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : wbs_accumulator
// Description : Accumulates (b+s) over a loaded number of steps and presents
//               the sum on a valid/ready result port. Three-state FSM:
//               IDLE -> ACCUM -> DONE. All outputs are registered.
// Revision    : 1.0 - initial release
// ============================================================================
module wbs_accumulator #(
    parameter int DW = 6,
    parameter int AW = 13
) (
    input  wire logic        clk,
    input  wire logic        reset,
    wbs_accumulator_if.slave bus
);

    localparam logic [1:0]    C_IDLE      = 2'd0;
    localparam logic [1:0]    C_ACCUM     = 2'd1;
    localparam logic [1:0]    C_DONE      = 2'd2;
    localparam logic [DW-1:0] C_COUNT_ONE = {{(DW-1){1'b0}}, 1'b1};

    logic [1:0]    state_q, state_d;
    logic [DW-1:0] w_q, w_d;
    logic [DW-1:0] count_q, count_d;
    logic [AW-1:0] acc_q, acc_d;
    logic          valid_q, valid_d;
    logic          busy_q, busy_d;
    logic          lost_q, lost_d;

    // Per-step term is the zero-extended DW+1-bit operand sum, widened to AW
    logic [DW:0]   w_term;
    logic [AW-1:0] w_term_ext;
    logic [DW-1:0] w_count_inc;

    assign w_term      = {1'b0, bus.b_in} + {1'b0, bus.s_in};
    assign w_term_ext  = {{(AW-DW-1){1'b0}}, w_term};
    assign w_count_inc = count_q + C_COUNT_ONE;

    // Next-state and datapath updates; a load always restarts from scratch
    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        count_d = count_q;
        acc_d   = acc_q;
        lost_d  = 1'b0;

        case (state_q)
            C_IDLE: begin
                if (bus.load_w_in) begin
                    w_d     = bus.w_in;
                    count_d = '0;
                    acc_d   = '0;
                    state_d = (bus.w_in != '0) ? C_ACCUM : C_DONE;
                end
            end
            C_ACCUM: begin
                if (bus.load_w_in) begin
                    // Abort: the partial sum is discarded, no result emitted
                    w_d     = bus.w_in;
                    count_d = '0;
                    acc_d   = '0;
                    state_d = (bus.w_in != '0) ? C_ACCUM : C_DONE;
                end else if (bus.cnt_in) begin
                    acc_d   = acc_q + w_term_ext;
                    count_d = w_count_inc;
                    if (w_count_inc == w_q) begin
                        state_d = C_DONE;
                    end
                end
            end
            C_DONE: begin
                if (bus.ready_in) begin
                    if (bus.load_w_in) begin
                        // Accept and start the next operation in one cycle
                        w_d     = bus.w_in;
                        count_d = '0;
                        acc_d   = '0;
                        state_d = (bus.w_in != '0) ? C_ACCUM : C_DONE;
                    end else begin
                        state_d = C_IDLE;
                    end
                end else if (bus.load_w_in) begin
                    // Result still pending: the load cannot be honoured
                    lost_d = 1'b1;
                end
            end
            default: begin
                state_d = C_IDLE;
            end
        endcase

        valid_d = (state_d == C_DONE);
        busy_d  = (state_d == C_ACCUM);
    end

    // State and output registers with asynchronous clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= C_IDLE;
            w_q     <= '0;
            count_q <= '0;
            acc_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            lost_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            count_q <= count_d;
            acc_q   <= acc_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            lost_q  <= lost_d;
        end
    end

    assign bus.result_out = acc_q;
    assign bus.count_out  = count_q;
    assign bus.valid_out  = valid_q;
    assign bus.busy_out   = busy_q;
    assign bus.lost_out   = lost_q;

endmodule
`default_nettype wire

// File: tb/tb_wbs_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_wbs_accumulator
// Description : Self-checking bench for wbs_accumulator: table of directed
//               vectors plus hand-written full-range and async-reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wbs_accumulator;

    localparam int DW = 6;
    localparam int AW = 13;
    localparam int NVEC = 25;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    wbs_accumulator_if #(.DW(DW), .AW(AW)) bus ();

    wbs_accumulator #(.DW(DW), .AW(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          load;
        logic [DW-1:0] w;
        logic          cnt;
        logic [DW-1:0] b;
        logic [DW-1:0] s;
        logic          ready;
        logic [AW-1:0] e_res;
        logic [DW-1:0] e_cnt;
        logic          e_valid;
        logic          e_busy;
        logic          e_lost;
    } vec_t;

    vec_t vecs [NVEC];

    function automatic vec_t mk(input logic ld, input int w, input logic cn,
                                input int b, input int s, input logic rdy,
                                input int er, input int ec, input logic ev,
                                input logic eb, input logic el);
        vec_t v;
        v.load = ld; v.w = DW'(w); v.cnt = cn; v.b = DW'(b); v.s = DW'(s);
        v.ready = rdy; v.e_res = AW'(er); v.e_cnt = DW'(ec);
        v.e_valid = ev; v.e_busy = eb; v.e_lost = el;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic ld, input int w, input logic cn,
                         input int b, input int s, input logic rdy);
        bus.load_w_in = ld;
        bus.w_in      = DW'(w);
        bus.cnt_in    = cn;
        bus.b_in      = DW'(b);
        bus.s_in      = DW'(s);
        bus.ready_in  = rdy;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input int er, input int ec,
                             input logic ev, input logic eb, input logic el);
        check({tag, ".result"}, int'(bus.result_out), er);
        check({tag, ".count"},  int'(bus.count_out),  ec);
        check({tag, ".valid"},  int'(bus.valid_out),  int'(ev));
        check({tag, ".busy"},   int'(bus.busy_out),   int'(eb));
        check({tag, ".lost"},   int'(bus.lost_out),   int'(el));
    endtask

    initial begin
        checks = 0;
        errors = 0;

        //             ld w  cn b  s  rdy  res cnt v  b  l
        // W=3, one idle cycle in the middle, ready already high at the last strobe
        vecs[0]  = mk(1, 3, 0, 0, 0, 0,    0,  0, 0, 1, 0);
        vecs[1]  = mk(0, 0, 1, 1, 2, 0,    3,  1, 0, 1, 0);
        vecs[2]  = mk(0, 0, 0, 9, 9, 0,    3,  1, 0, 1, 0);
        vecs[3]  = mk(0, 0, 1, 3, 4, 0,   10,  2, 0, 1, 0);
        vecs[4]  = mk(0, 0, 1, 5, 6, 1,   21,  3, 1, 0, 0);
        vecs[5]  = mk(0, 0, 0, 0, 0, 1,   21,  3, 0, 0, 0);
        // Strobe in IDLE is ignored
        vecs[6]  = mk(0, 0, 1, 7, 7, 0,   21,  3, 0, 0, 0);
        // W=0 goes straight to DONE; same-cycle strobe ignored
        vecs[7]  = mk(1, 0, 1, 5, 5, 0,    0,  0, 1, 0, 0);
        vecs[8]  = mk(0, 0, 0, 0, 0, 1,    0,  0, 0, 0, 0);
        // W=4, two strobes, then restart with W=2 (same-cycle strobe ignored)
        vecs[9]  = mk(1, 4, 0, 0, 0, 0,    0,  0, 0, 1, 0);
        vecs[10] = mk(0, 0, 1, 5, 5, 0,   10,  1, 0, 1, 0);
        vecs[11] = mk(0, 0, 1, 7, 7, 0,   24,  2, 0, 1, 0);
        vecs[12] = mk(1, 2, 1, 9, 9, 0,    0,  0, 0, 1, 0);
        vecs[13] = mk(0, 0, 1,10,10, 0,   20,  1, 0, 1, 0);
        vecs[14] = mk(0, 0, 1, 1, 1, 0,   22,  2, 1, 0, 0);
        // Result held for 5 cycles with ready low; strobes in DONE ignored
        vecs[15] = mk(0, 0, 1, 3, 3, 0,   22,  2, 1, 0, 0);
        vecs[16] = mk(0, 0, 0, 0, 0, 0,   22,  2, 1, 0, 0);
        vecs[17] = mk(0, 0, 1, 8, 1, 0,   22,  2, 1, 0, 0);
        vecs[18] = mk(0, 0, 0, 0, 0, 0,   22,  2, 1, 0, 0);
        vecs[19] = mk(0, 0, 0, 0, 0, 0,   22,  2, 1, 0, 0);
        // Load while pending: dropped, lost pulses exactly once
        vecs[20] = mk(1, 5, 0, 0, 0, 0,   22,  2, 1, 0, 1);
        vecs[21] = mk(0, 0, 0, 0, 0, 0,   22,  2, 1, 0, 0);
        // Accept plus load (W=1) in one cycle, then the single strobe
        vecs[22] = mk(1, 1, 0, 0, 0, 1,    0,  0, 0, 1, 0);
        vecs[23] = mk(0, 0, 1, 2, 3, 0,    5,  1, 1, 0, 0);
        vecs[24] = mk(0, 0, 0, 0, 0, 1,    5,  1, 0, 0, 0);

        drive(0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        #12;
        check_all("reset", 0, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].load, int'(vecs[i].w), vecs[i].cnt,
                  int'(vecs[i].b), int'(vecs[i].s), vecs[i].ready);
            step();
            check_all($sformatf("vec%0d", i), int'(vecs[i].e_res),
                      int'(vecs[i].e_cnt), vecs[i].e_valid,
                      vecs[i].e_busy, vecs[i].e_lost);
        end

        // Full range: 63 strobes of 63+63 = 126 each gives 7938, no wrap
        drive(1, 63, 0, 0, 0, 0);
        step();
        check_all("max.load", 0, 0, 0, 1, 0);
        for (int k = 0; k < 63; k++) begin
            drive(0, 0, 1, 63, 63, 0);
            step();
        end
        check_all("max.done", 7938, 63, 1, 0, 0);
        drive(0, 0, 0, 0, 0, 1);
        step();
        check_all("max.accept", 7938, 63, 0, 0, 0);

        // Asynchronous reset in the middle of an accumulation
        drive(1, 5, 0, 0, 0, 0);
        step();
        drive(0, 0, 1, 1, 1, 0);
        step();
        drive(0, 0, 1, 1, 1, 0);
        step();
        check_all("arst.before", 4, 2, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 0);
        #2;
        reset = 1'b1;
        #1;
        check_all("arst.during", 0, 0, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;
        drive(1, 2, 0, 0, 0, 0);
        step();
        check_all("arst.load", 0, 0, 0, 1, 0);
        drive(0, 0, 1, 1, 1, 0);
        step();
        drive(0, 0, 1, 2, 2, 0);
        step();
        check_all("arst.done", 6, 2, 1, 0, 0);
        drive(0, 0, 0, 0, 0, 1);
        step();
        check_all("arst.accept", 6, 2, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
